// File: rtl/debouncer_bank.sv
// debouncer_bank
//   Multi-channel keypad debouncer. Each raw pin is synchronised, debounced
//   and turned into a clean level plus one-cycle rise/fall events. Long-press
//   and auto-repeat events are also produced, so downstream scan logic can
//   act on events instead of polling levels.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   noisy       raw asynchronous pin levels, one per channel
//   clean       debounced level, 1 = pressed (after ACTIVE_LOW mapping)
//   rise        one-cycle pulse when clean goes 0->1
//   fall        one-cycle pulse when clean goes 1->0
//   long_press  one-cycle pulse at the long-press threshold and on each repeat
//   any_active  OR of clean, registered alongside clean
module debouncer_bank #(
    parameter int CHANNELS          = 4,
    parameter int ACTIVE_LOW        = 0,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 27000,
    parameter int CNT_W             = 16,
    parameter int LONG_PRESS_CYCLES = 2700000,
    parameter int REPEAT_CYCLES     = 675000,
    parameter int HOLD_W            = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press,
    output logic                any_active
);

    localparam logic              IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LP_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] RP_LAST  =
        HOLD_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

    logic [CHANNELS-1:0] clean_nxt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_p0;
        logic                   s_p0;
        logic [CNT_W-1:0]       db_cnt_p1;
        logic [CNT_W-1:0]       db_cnt_nxt;
        logic                   clean_p1;
        logic                   clean_d;
        logic                   rise_p1;
        logic                   fall_p1;
        logic [HOLD_W-1:0]      hold_p1;
        logic [HOLD_W-1:0]      hold_nxt;
        logic [HOLD_W-1:0]      hold_last;
        logic                   rep_p1;
        logic                   rep_nxt;
        logic                   lp_p1;
        logic                   lp_nxt;

        // ---- stage p0: synchroniser, polarity mapped after the last flop ----
        assign s_p0 = sync_p0[SYNC_STAGES-1] ^ IDLE_LVL;

        // ---- stage p1: debounce and hold/long-press next-state ----
        always_comb begin
            db_cnt_nxt = db_cnt_p1;
            clean_d    = clean_p1;
            if (s_p0 == clean_p1) begin
                db_cnt_nxt = '0;
            end else if (db_cnt_p1 == DB_LAST) begin
                clean_d    = s_p0;
                db_cnt_nxt = '0;
            end else begin
                db_cnt_nxt = db_cnt_p1 + CNT_W'(1);
            end
        end

        // rep_p1 marks that the first long press already fired; the period
        // then switches from the long-press threshold to the repeat period.
        assign hold_last = rep_p1 ? RP_LAST : LP_LAST;

        always_comb begin
            hold_nxt = hold_p1;
            rep_nxt  = rep_p1;
            lp_nxt   = 1'b0;
            if (!clean_p1 || !clean_d) begin
                // Not pressed yet (includes the rise edge) or releasing now:
                // release wins over a coinciding threshold.
                hold_nxt = '0;
                rep_nxt  = 1'b0;
            end else if (rep_p1 && (REPEAT_CYCLES == 0)) begin
                hold_nxt = hold_p1;
            end else if (hold_p1 == hold_last) begin
                lp_nxt   = 1'b1;
                rep_nxt  = 1'b1;
                hold_nxt = (REPEAT_CYCLES > 0) ? '0 : hold_p1;
            end else begin
                hold_nxt = hold_p1 + HOLD_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_p0   <= {SYNC_STAGES{IDLE_LVL}};
                db_cnt_p1 <= '0;
                clean_p1  <= 1'b0;
                rise_p1   <= 1'b0;
                fall_p1   <= 1'b0;
                hold_p1   <= '0;
                rep_p1    <= 1'b0;
                lp_p1     <= 1'b0;
            end else begin
                sync_p0   <= {sync_p0[SYNC_STAGES-2:0], noisy[i]};
                db_cnt_p1 <= db_cnt_nxt;
                clean_p1  <= clean_d;
                rise_p1   <= clean_d & ~clean_p1;
                fall_p1   <= ~clean_d & clean_p1;
                hold_p1   <= hold_nxt;
                rep_p1    <= rep_nxt;
                lp_p1     <= lp_nxt;
            end
        end

        assign clean_nxt[i]  = clean_d;
        assign clean[i]      = clean_p1;
        assign rise[i]       = rise_p1;
        assign fall[i]       = fall_p1;
        assign long_press[i] = lp_p1;
    end

    // ---- stage p1: summary flag, updated in the same cycle as clean ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_active <= 1'b0;
        end else begin
            any_active <= |clean_nxt;
        end
    end

endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
Parametrised multi-channel debouncer for the keypad front end. It takes a vector of raw, asynchronous button/row lines, synchronises and debounces each channel independently, and emits clean levels plus one-cycle press/release event pulses. It also emits long-press and auto-repeat pulses, so the scan/decode logic consumes events instead of levels.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
ACTIVE_LOW, 0, 1 = pin level 0 means pressed; inversion applied after synchroniser
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
DEBOUNCE_CYCLES, 27000, consecutive differing samples required to accept a new level (>=1)
CNT_W, 16, debounce counter width; DEBOUNCE_CYCLES must be < 2**CNT_W
LONG_PRESS_CYCLES, 2700000, cycles of clean press before first long_press pulse (>=1)
REPEAT_CYCLES, 675000, period of repeat pulses after first long_press; 0 disables repeat
HOLD_W, 24, hold counter width; max(LONG_PRESS_CYCLES, REPEAT_CYCLES) < 2**HOLD_W

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
noisy  input  CHANNELS  raw asynchronous pin levels
clean  output  CHANNELS  debounced level, 1 = pressed (after ACTIVE_LOW mapping)
rise  output  CHANNELS  one-cycle pulse when clean goes 0->1
fall  output  CHANNELS  one-cycle pulse when clean goes 1->0
long_press  output  CHANNELS  one-cycle pulse at long-press threshold and each repeat
any_active  output  1  OR of clean

Behaviour:
- Reset (rst=0, async): clean, rise, fall, long_press, any_active = 0. All counters = 0. Sync flops = idle pin level (ACTIVE_LOW ? 1 : 0). Reset mid-operation aborts everything. After release, a pin still held must be fully re-synchronised and re-debounced before rise.
- Sync: noisy[i] passes through SYNC_STAGES flops. s[i] = last stage XOR ACTIVE_LOW.
- Debounce, per channel, every edge:
  - If s == clean: debounce counter <= 0.
  - Else: counter++. When counter == DEBOUNCE_CYCLES-1 at the edge, clean <= s and counter <= 0.
  - Net effect: clean updates on the DEBOUNCE_CYCLES-th consecutive edge with s != clean.
  - Any single matching sample (glitch) restarts the count from 0.
- Latency: a clean pin step first sampled at edge 1 changes clean at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- rise/fall are registered and asserted in the same cycle clean changes, for exactly one cycle.
- Hold/long press, per channel:
  - The hold counter is 0 while clean == 0.
  - While clean == 1 it increments each edge.
  - First long_press pulse at the LONG_PRESS_CYCLES-th edge after the rise cycle.
  - If REPEAT_CYCLES > 0: the counter then reloads, and long_press pulses every REPEAT_CYCLES edges while clean stays 1.
  - If REPEAT_CYCLES == 0: the counter stops (saturates) and no further pulses occur.
- Release priority: on the edge where clean falls, the hold counter clears and no long_press is issued, even if the threshold would coincide.
- Pulse exclusivity: rise and fall never coincide on one channel. long_press never coincides with rise or fall on the same channel.
- Channels are fully independent. Multiple channels may pulse in the same cycle.
- any_active is registered, equal to |clean (same-cycle update as clean).
- Counters never wrap. The debounce counter is bounded by DEBOUNCE_CYCLES-1; the hold counter by its threshold.

Test Plan (CHANNELS=4, ACTIVE_LOW=0, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, REPEAT_CYCLES=16):
1. Reset: drive noisy=4'b1111 with rst=0 -> all outputs 0. Release rst, hold noisy -> clean=4'b1111 and rise=4'b1111 (single pulse) at edge 10 after release; any_active=1 same cycle.
2. Bounce: ch0 toggles 1/0 every 3 cycles for 40 cycles, then steady 1 -> no rise during bouncing. clean[0]=1 exactly 10 edges after the final steady level is first sampled. Then steady 0 -> fall[0] one pulse 10 edges later.
3. Long press with repeat: ch2 held -> rise[2], then long_press[2] 32 edges later, then every 16 edges (check 3 pulses). Release -> fall[2] with no long_press in the fall cycle, and no pulses after.
4. Glitch rejection: clean[1]=1 steady; ch1 drops to 0 for 7 cycles then returns -> no fall[1], clean[1] stays 1, long_press cadence unaffected.
5. Async reset mid-count: ch3 pressed, rst pulsed low at debounce count 5 -> outputs 0 immediately. After release, the full 10-edge latency applies again.
6. ACTIVE_LOW=1, REPEAT_CYCLES=0: pin 0 held -> rise after 10 edges. Exactly one long_press 32 edges later, then none for 100 more cycles.
